// File: rtl/riscv_types_pkg.sv
// Shared RV32IM pipeline types used by the hazard scoreboard and its forwarding selectors.
package riscv_types_pkg;

  localparam int unsigned SB_TAG_W  = 5;
  localparam int unsigned FWD_SEL_W = 5;

  // Wide enough for any legal completion-port count; narrower tags are zero-extended.
  typedef logic [SB_TAG_W-1:0]  sb_tag_t;
  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_SEL_REG = '0;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_RAW,
    HZ_WAW,
    HZ_CAP
  } hz_cause_e;

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// Priority-match encoder: picks the youngest bypass stage whose destination matches the source.
module fwd_select
  import riscv_types_pkg::*;
#(
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [4:0]           src_i,
  input  logic [NUM_FWD-1:0]   fwd_valid_i,
  input  logic [NUM_FWD*5-1:0] fwd_rd_i,
  output logic [SEL_W-1:0]     sel_o
);

  logic hit;

  always_comb begin
    sel_o = SEL_W'(FWD_SEL_REG);
    hit   = 1'b0;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (!hit && (src_i != 5'd0) && fwd_valid_i[k] && (fwd_rd_i[k*5 +: 5] == src_i)) begin
        sel_o = SEL_W'(k + 1);
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard for long-latency writers plus N-stage operand forwarding select.
// Optional stall-cause counters are enabled by defining HAZARD_SB_PERF_EN.
module hazard_scoreboard
  import riscv_types_pkg::*;
#(
  parameter int unsigned NUM_CMPL     = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned NUM_FWD      = 2,
  localparam int unsigned TAG_W = (NUM_CMPL > 1) ? $clog2(NUM_CMPL) : 1,
  localparam int unsigned SEL_W = $clog2(NUM_FWD + 1),
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [4:0]            issue_rs1_i,
  input  logic [4:0]            issue_rs2_i,
  input  logic [4:0]            issue_rd_i,
  input  logic                  issue_rd_we_i,
  input  logic                  issue_long_i,
  input  logic [TAG_W-1:0]      issue_tag_i,
  input  logic                  kill_i,
  input  logic [NUM_CMPL-1:0]   cmpl_valid_i,
  input  logic [NUM_CMPL*5-1:0] cmpl_rd_i,
  input  logic [NUM_FWD-1:0]    fwd_valid_i,
  input  logic [NUM_FWD*5-1:0]  fwd_rd_i,
  input  logic [4:0]            ex_rs1_i,
  input  logic [4:0]            ex_rs2_i,
  output logic [SEL_W-1:0]      fwd_a_sel_o,
  output logic [SEL_W-1:0]      fwd_b_sel_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      inflight_o,
  output logic                  sb_err_o
`ifdef HAZARD_SB_PERF_EN
  ,
  output logic [31:0]           stall_raw_cnt_o,
  output logic [31:0]           stall_waw_cnt_o,
  output logic [31:0]           stall_cap_cnt_o
`endif
);

  logic [31:0]      pending_q, pending_d;
  sb_tag_t          tag_q [32];
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] ndec;
  logic             err_q, err_d;
  logic [4:0]       cr;
  logic             raw, waw, cap, alloc;
  hz_cause_e        cause;

  always_comb begin
    raw   = ((issue_rs1_i != 5'd0) && pending_q[issue_rs1_i]) ||
            ((issue_rs2_i != 5'd0) && pending_q[issue_rs2_i]);
    waw   = issue_rd_we_i && (issue_rd_i != 5'd0) && pending_q[issue_rd_i];
    cap   = issue_long_i && (inflight_q == CNT_W'(MAX_INFLIGHT));
    cause = HZ_NONE;
    if (issue_valid_i) begin
      if (raw)      cause = HZ_RAW;
      else if (waw) cause = HZ_WAW;
      else if (cap) cause = HZ_CAP;
    end
  end

  assign stall_o       = (cause != HZ_NONE);
  assign issue_ready_o = !stall_o;
  assign alloc = issue_valid_i && !stall_o && !kill_i &&
                 issue_long_i && issue_rd_we_i && (issue_rd_i != 5'd0);

  // Every port is judged against registered state, so two ports naming the same
  // register can retire it at most once (tag matches one port only).
  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    ndec      = '0;
    cr        = '0;
    for (int unsigned p = 0; p < NUM_CMPL; p++) begin
      cr = cmpl_rd_i[p*5 +: 5];
      if (cmpl_valid_i[p]) begin
        if ((cr != 5'd0) && pending_q[cr] && (tag_q[cr] == sb_tag_t'(p))) begin
          pending_d[cr] = 1'b0;
          ndec          = ndec + CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end
    if (alloc) pending_d[issue_rd_i] = 1'b1;
    inflight_d = inflight_q + CNT_W'(alloc) - ndec;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) tag_q[i] <= '0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      if (alloc) tag_q[issue_rd_i] <= sb_tag_t'(issue_tag_i);
    end
  end

  assign inflight_o = inflight_q;
  assign sb_err_o   = err_q;

  fwd_select #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd_a (
    .src_i       (ex_rs1_i),
    .fwd_valid_i (fwd_valid_i),
    .fwd_rd_i    (fwd_rd_i),
    .sel_o       (fwd_a_sel_o)
  );

  fwd_select #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd_b (
    .src_i       (ex_rs2_i),
    .fwd_valid_i (fwd_valid_i),
    .fwd_rd_i    (fwd_rd_i),
    .sel_o       (fwd_b_sel_o)
  );

`ifdef HAZARD_SB_PERF_EN
  logic [31:0] raw_cnt_q, waw_cnt_q, cap_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      raw_cnt_q <= '0;
      waw_cnt_q <= '0;
      cap_cnt_q <= '0;
    end else begin
      unique case (cause)
        HZ_RAW:  if (raw_cnt_q != '1) raw_cnt_q <= raw_cnt_q + 32'd1;
        HZ_WAW:  if (waw_cnt_q != '1) waw_cnt_q <= waw_cnt_q + 32'd1;
        HZ_CAP:  if (cap_cnt_q != '1) cap_cnt_q <= cap_cnt_q + 32'd1;
        default: ;
      endcase
    end
  end

  assign stall_raw_cnt_o = raw_cnt_q;
  assign stall_waw_cnt_o = waw_cnt_q;
  assign stall_cap_cnt_o = cap_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed plus randomized bench for hazard_scoreboard against a set-based scoreboard model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_ready;
  logic [4:0] rs1, rs2, rd;
  logic       rd_we, is_long, kill;
  logic [0:0] tag;
  logic [1:0] cmpl_valid;
  logic [9:0] cmpl_rd;
  logic [1:0] fwd_valid;
  logic [9:0] fwd_rd;
  logic [4:0] ex_rs1, ex_rs2;
  logic [1:0] fa_sel, fb_sel;
  logic       stall;
  logic [2:0] inflight;
  logic       sb_err;

  hazard_scoreboard #(.NUM_CMPL(2), .MAX_INFLIGHT(4), .NUM_FWD(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_rs1_i(rs1), .issue_rs2_i(rs2), .issue_rd_i(rd), .issue_rd_we_i(rd_we),
    .issue_long_i(is_long), .issue_tag_i(tag), .kill_i(kill),
    .cmpl_valid_i(cmpl_valid), .cmpl_rd_i(cmpl_rd),
    .fwd_valid_i(fwd_valid), .fwd_rd_i(fwd_rd), .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2),
    .fwd_a_sel_o(fa_sel), .fwd_b_sel_o(fb_sel), .stall_o(stall),
    .inflight_o(inflight), .sb_err_o(sb_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: set of pending registers mapped to their completion port.
  int tagof[int];
  bit merr;
  bit chk_en = 1'b0;
  int exp_stall, exp_fa, exp_fb, exp_infl, exp_err;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int fsel(input logic [4:0] s);
    for (int k = 0; k < 2; k++)
      if (s != 0 && fwd_valid[k] && fwd_rd[k*5 +: 5] == s) return k + 1;
    return 0;
  endfunction

  function automatic bit is_pend(input logic [4:0] r);
    return (r != 0) && tagof.exists(int'(r));
  endfunction

  task automatic compute_exp();
    bit raw, waw, cap;
    raw = is_pend(rs1) || is_pend(rs2);
    waw = rd_we && is_pend(rd);
    cap = is_long && (tagof.num() == 4);
    exp_stall = (issue_valid && (raw || waw || cap)) ? 1 : 0;
    exp_fa    = fsel(ex_rs1);
    exp_fb    = fsel(ex_rs2);
    exp_infl  = tagof.num();
    exp_err   = merr;
  endtask

  task automatic model_update();
    int retire[$];
    if (!rst_n) begin
      tagof.delete();
      merr = 1'b0;
      return;
    end
    for (int p = 0; p < 2; p++) begin
      if (cmpl_valid[p]) begin
        int r = int'(cmpl_rd[p*5 +: 5]);
        if (r != 0 && tagof.exists(r) && tagof[r] == p) retire.push_back(r);
        else merr = 1'b1;
      end
    end
    foreach (retire[i]) tagof.delete(retire[i]);
    if (issue_valid && exp_stall == 0 && !kill && is_long && rd_we && rd != 0)
      tagof[int'(rd)] = int'(tag);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", int'(stall), exp_stall);
      chk("issue_ready", int'(issue_ready), 1 - exp_stall);
      chk("fwd_a_sel", int'(fa_sel), exp_fa);
      chk("fwd_b_sel", int'(fb_sel), exp_fb);
      chk("inflight", int'(inflight), exp_infl);
      chk("sb_err", int'(sb_err), exp_err);
    end
  end

  // One clock with current inputs; returns one time unit after the rising edge.
  task automatic cyc();
    compute_exp();
    chk_en = 1'b1;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; issue_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; rd_we = 1'b0;
    is_long = 1'b0; tag = '0; kill = 1'b0; cmpl_valid = '0; cmpl_rd = '0;
    fwd_valid = '0; fwd_rd = '0; ex_rs1 = '0; ex_rs2 = '0;
  endtask

  task automatic do_reset();
    idle(); rst_n = 1'b0; cyc(); rst_n = 1'b1;
  endtask

  task automatic issue(input int r1, input int r2, input int d, input bit lng, input int tg);
    issue_valid = 1'b1; rs1 = 5'(r1); rs2 = 5'(r2); rd = 5'(d);
    rd_we = (d != 0); is_long = lng; tag = 1'(tg);
  endtask

  initial begin
    idle(); rst_n = 1'b0;
    cyc(); cyc();
    idle();
    chk("reset_inflight", int'(inflight), 0);
    chk("reset_err", int'(sb_err), 0);
    chk("reset_stall", int'(stall), 0);

    // Long write to x5, dependent read stalls until completion retires it.
    issue(0, 0, 5, 1, 0); #1;
    chk("x5_issue_stall", int'(stall), 0);
    cyc(); idle();
    chk("x5_inflight", int'(inflight), 1);
    chk("model_x5_pending", int'(tagof.exists(5)), 1);
    issue(5, 0, 0, 0, 0); #1;
    chk("x5_raw_stall", int'(stall), 1);
    cmpl_valid = 2'b01; cmpl_rd = 10'd5; #1;
    chk("x5_cmpl_same_cycle", int'(stall), 1);
    cyc(); cmpl_valid = '0; #1;
    chk("x5_unstall", int'(stall), 0);
    chk("x5_inflight0", int'(inflight), 0);
    cyc();

    // Capacity: four long writes fill the scoreboard.
    do_reset();
    for (int i = 1; i <= 4; i++) begin idle(); issue(0, 0, i, 1, 0); cyc(); end
    idle();
    chk("cap_inflight4", int'(inflight), 4);
    chk("model_cap_num", tagof.num(), 4);
    issue(0, 0, 6, 1, 0); cmpl_valid = 2'b01; cmpl_rd = 10'd2; #1;
    chk("cap_stall", int'(stall), 1);
    cyc(); cmpl_valid = '0; #1;
    chk("cap_unstall", int'(stall), 0);
    chk("cap_inflight3", int'(inflight), 3);
    cyc(); idle(); #1;
    chk("cap_refill", int'(inflight), 4);

    // Kill suppresses the long issue entirely.
    do_reset();
    issue(0, 0, 7, 1, 0); kill = 1'b1; cyc(); idle();
    chk("kill_inflight", int'(inflight), 0);
    issue(7, 0, 0, 0, 0); #1;
    chk("kill_no_stall", int'(stall), 0);
    cyc();

    // Completion on the wrong port is a sticky error and leaves the entry pending.
    do_reset();
    issue(0, 0, 9, 1, 0); cyc(); idle();
    cmpl_valid = 2'b10; cmpl_rd = {5'd9, 5'd0}; cyc(); idle();
    chk("tagmis_err", int'(sb_err), 1);
    chk("tagmis_inflight", int'(inflight), 1);
    issue(9, 0, 0, 0, 0); #1;
    chk("tagmis_pending", int'(stall), 1);
    cyc(); idle(); cyc();
    chk("err_sticky", int'(sb_err), 1);
    do_reset();
    chk("err_cleared", int'(sb_err), 0);

    // Simultaneous completions on both ports.
    issue(0, 0, 3, 1, 0); cyc();
    issue(0, 0, 4, 1, 1); cyc(); idle();
    chk("dual_inflight2", int'(inflight), 2);
    cmpl_valid = 2'b11; cmpl_rd = {5'd4, 5'd3}; cyc(); idle();
    chk("dual_inflight0", int'(inflight), 0);
    chk("dual_no_err", int'(sb_err), 0);

    // Forwarding priority and x0.
    fwd_valid = 2'b11; fwd_rd = {5'd8, 5'd8}; ex_rs1 = 5'd8; ex_rs2 = 5'd0; #1;
    chk("fwd_a_young", int'(fa_sel), 1);
    chk("fwd_b_x0", int'(fb_sel), 0);
    fwd_valid = 2'b10; #1;
    chk("fwd_a_old", int'(fa_sel), 2);
    cyc();

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      rst_n       = ($urandom_range(0, 99) >= 2);
      issue_valid = ($urandom_range(0, 9) < 7);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      rd_we   = ($urandom_range(0, 9) < 8);
      is_long = $urandom_range(0, 1);
      tag     = 1'($urandom_range(0, 1));
      kill    = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 9) < 3) begin
          int cand[$];
          foreach (tagof[r]) if (tagof[r] == p) cand.push_back(r);
          cmpl_valid[p] = 1'b1;
          if (cand.size() != 0 && $urandom_range(0, 19) != 0)
            cmpl_rd[p*5 +: 5] = 5'(cand[$urandom_range(0, cand.size() - 1)]);
          else
            cmpl_rd[p*5 +: 5] = 5'($urandom_range(0, 7));
        end
      end
      fwd_valid = 2'($urandom_range(0, 3));
      fwd_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_rs1 = 5'($urandom_range(0, 7)); ex_rs2 = 5'($urandom_range(0, 7));
      cyc();
    end

    idle(); cyc();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
